// File: rtl/mem_stage_pkg.sv
// Shared widths and bus payload layouts for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned REG_ADDR_W       = 5;
  localparam int unsigned STAGE_W          = 3;
  localparam int unsigned BEN_W            = 4;
  localparam int unsigned EXE_TO_MEM_BUS_WD = 79;
  localparam int unsigned MEM_TO_WB_BUS_WD  = 73;
  localparam int unsigned MEM_TO_BY_BUS_WD  = 40;

  typedef struct packed {
    logic [STAGE_W-1:0]    wdata_valid_stage;
    logic                  rf_w_en;
    logic                  rf_w_data;
    logic                  data_ram_wd;
    logic [BEN_W-1:0]      b_en;
    logic [REG_ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     inst_pc;
  } exe_to_mem_t;

  typedef struct packed {
    logic [STAGE_W-1:0]    wdata_valid_stage;
    logic                  rf_w_en;
    logic [REG_ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0]     mem_result;
    logic [DATA_W-1:0]     inst_pc;
  } mem_to_wb_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rf_w_addr;
    logic [DATA_W-1:0]     mem_result;
    logic                  wdata_valid;
    logic                  mem_valid;
    logic                  rf_w_en;
  } mem_to_by_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: one-hot byte select with sign extension, or word pass-through.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] raw_rdata,
  input  logic [BEN_W-1:0]  b_en,
  input  logic              wd,
  output logic [DATA_W-1:0] aligned_load
);

  logic [7:0] sel_byte;
  logic       byte_ok;

  always_comb begin
    sel_byte = 8'h00;
    byte_ok  = 1'b1;
    case (b_en)
      4'b0001: sel_byte = raw_rdata[7:0];
      4'b0010: sel_byte = raw_rdata[15:8];
      4'b0100: sel_byte = raw_rdata[23:16];
      4'b1000: sel_byte = raw_rdata[31:24];
      default: byte_ok  = 1'b0;
    endcase
  end

  always_comb begin
    aligned_load = raw_rdata;
    if (wd) begin
      aligned_load = byte_ok ? {{(DATA_W-8){sel_byte[7]}}, sel_byte} : DATA_W'(0);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: captures EXE payload, merges Data RAM read data with a
// stall-safe hold buffer, and drives WB and bypass buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
  input  logic                         EXE_to_MEM_valid,
  output logic                         MEM_allow_in,
  input  logic [DATA_W-1:0]            data_ram_r_data,
  input  logic                         WB_allow_in,
  output logic                         MEM_to_WB_valid,
  output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
  output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus
);

  exe_to_mem_t       exe_reg;
  logic              mem_valid;
  logic              first_cycle;
  logic              buf_valid;
  logic [DATA_W-1:0] rdata_buf;
  logic [DATA_W-1:0] raw_rdata;
  logic [DATA_W-1:0] aligned_load;
  logic [DATA_W-1:0] mem_result;
  logic              accept;
  logic              leave;
  mem_to_wb_t        wb_bus;
  mem_to_by_t        by_bus;

  assign MEM_allow_in    = ~mem_valid | WB_allow_in;
  assign MEM_to_WB_valid = mem_valid;
  assign accept          = MEM_allow_in & EXE_to_MEM_valid;
  assign leave           = mem_valid & WB_allow_in;

  // Pipeline register and valid bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      exe_reg     <= '0;
      first_cycle <= 1'b0;
    end else begin
      first_cycle <= accept;
      if (MEM_allow_in) begin
        mem_valid <= EXE_to_MEM_valid;
      end
      if (accept) begin
        exe_reg <= exe_to_mem_t'(EXE_to_MEM_bus);
      end
    end
  end

  // RAM data is only ours in the first cycle; keep a copy if WB stalls us then
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      rdata_buf <= '0;
    end else if (leave) begin
      buf_valid <= 1'b0;
    end else if (first_cycle & mem_valid & ~WB_allow_in) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_ram_r_data;
    end
  end

  assign raw_rdata = buf_valid ? rdata_buf : data_ram_r_data;

  load_align u_load_align (
    .raw_rdata    (raw_rdata),
    .b_en         (exe_reg.b_en),
    .wd           (exe_reg.data_ram_wd),
    .aligned_load (aligned_load)
  );

  assign mem_result = exe_reg.rf_w_data ? aligned_load : exe_reg.alu_result;

  always_comb begin
    wb_bus                   = '0;
    wb_bus.wdata_valid_stage = exe_reg.wdata_valid_stage;
    wb_bus.rf_w_en           = exe_reg.rf_w_en;
    wb_bus.rf_w_addr         = exe_reg.rf_w_addr;
    wb_bus.mem_result        = mem_result;
    wb_bus.inst_pc           = exe_reg.inst_pc;
  end

  // Bypass data is usable once it was final at EXE or MEM
  always_comb begin
    by_bus             = '0;
    by_bus.rf_w_addr   = exe_reg.rf_w_addr;
    by_bus.mem_result  = mem_result;
    by_bus.wdata_valid = mem_valid & (exe_reg.wdata_valid_stage[0] | exe_reg.wdata_valid_stage[1]);
    by_bus.mem_valid   = mem_valid;
    by_bus.rf_w_en     = exe_reg.rf_w_en;
  end

  assign MEM_to_WB_bus = wb_bus;
  assign MEM_to_BY_bus = by_bus;

endmodule
